// File: rtl/conv_col_feeder_if.sv
// ---------------------------------------------------------------------------
// conv_col_feeder_if
//   Handshake bundle for conv_col_feeder: the raster pixel input stream and
//   the column-vector output stream.
//   Signals:
//     in_valid / in_ready / in_pix        pixel stream (raster order)
//     col_valid / col_ready / col_data    column vector stream
//     col_x / col_eol / col_eof           column position and row/frame tags
//   Modports:
//     master  environment side (drives pixels, accepts columns)
//     slave   feeder side
// ---------------------------------------------------------------------------
interface conv_col_feeder_if #(
  parameter int K_H   = 3,
  parameter int IMG_W = 15,
  parameter int PIX_W = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [PIX_W-1:0]           in_pix;
  logic                       col_valid;
  logic                       col_ready;
  logic [K_H*PIX_W-1:0]       col_data;
  logic [$clog2(IMG_W)-1:0]   col_x;
  logic                       col_eol;
  logic                       col_eof;

  modport master (
    output in_valid, in_pix, col_ready,
    input  in_ready, col_valid, col_data, col_x, col_eol, col_eof
  );

  modport slave (
    input  in_valid, in_pix, col_ready,
    output in_ready, col_valid, col_data, col_x, col_eol, col_eof
  );
endinterface

// File: rtl/conv_col_feeder.sv
// ---------------------------------------------------------------------------
// conv_col_feeder
//   Upstream feeder for the 3x3 conv datapath. Accepts a raster-order stream
//   of unsigned pixels and emits one K_H-tall column per accepted pixel:
//   the current pixel plus the same-x pixels of the previous K_H-1 rows,
//   taken from K_H-1 line buffers of IMG_W pixels each.
//   Ports:
//     clk    rising-edge clock
//     rst    synchronous reset, active-high (wins over clear)
//     clear  synchronous frame flush: counters and output register to 0,
//            a pixel offered in the same cycle is dropped
//     bus    conv_col_feeder_if.slave (pixel in / column out handshakes)
//   col_data layout: lowest slice = row y-K_H+1 (top), highest = row y.
//   Build option:
//     CONV_FEED_PAD_EN  emit columns for rows 0..K_H-2 as well, with slices
//                       for rows above the image forced to zero.
//     (undefined)       only rows y >= K_H-1 produce columns.
// ---------------------------------------------------------------------------
module conv_col_feeder #(
  parameter int K_H   = 3,
  parameter int IMG_W = 15,
  parameter int IMG_H = 16,
  parameter int PIX_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  conv_col_feeder_if.slave   bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = K_H * PIX_W;

  localparam logic [XW-1:0] X_LAST   = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_STREAM = YW'(K_H - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic          accept;
  logic          emit;
  logic          x_last;

  // rd_col = {in_pix, lb[K_H-2][x], ..., lb[0][x]}; each line buffer's new
  // value at x is the slice directly above it, so the buffers shift upward.
  logic [CW-1:0] rd_col;
  logic [CW-1:0] col_next;

  logic          col_valid_q;
  logic [CW-1:0] col_data_q;
  logic [XW-1:0] col_x_q;
  logic          col_eol_q;
  logic          col_eof_q;

  assign bus.in_ready  = !col_valid_q || bus.col_ready;
  assign bus.col_valid = col_valid_q;
  assign bus.col_data  = col_data_q;
  assign bus.col_x     = col_x_q;
  assign bus.col_eol   = col_eol_q;
  assign bus.col_eof   = col_eof_q;

  assign accept = bus.in_valid && bus.in_ready && !clear;
  assign x_last = (x == X_LAST);

`ifdef CONV_FEED_PAD_EN
  assign emit = 1'b1;
`else
  assign emit = (y >= Y_STREAM);
`endif

  assign rd_col[CW-1 -: PIX_W]   = bus.in_pix;
  assign col_next[CW-1 -: PIX_W] = bus.in_pix;

  for (genvar k = 0; k < K_H - 1; k++) begin : g_row
    logic [PIX_W-1:0] mem [IMG_W];

    assign rd_col[k*PIX_W +: PIX_W] = mem[x];

    always_ff @(posedge clk) begin
      if (accept) begin
        mem[x] <= rd_col[(k+1)*PIX_W +: PIX_W];
      end
    end

`ifdef CONV_FEED_PAD_EN
    // Slice k holds row y-(K_H-1-k); zero it while that row is above the frame.
    assign col_next[k*PIX_W +: PIX_W] =
      (y >= YW'(K_H - 1 - k)) ? mem[x] : '0;
`else
    assign col_next[k*PIX_W +: PIX_W] = mem[x];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (x_last) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      col_valid_q <= 1'b0;
      col_data_q  <= '0;
      col_x_q     <= '0;
      col_eol_q   <= 1'b0;
      col_eof_q   <= 1'b0;
    end else if (accept && emit) begin
      col_valid_q <= 1'b1;
      col_data_q  <= col_next;
      col_x_q     <= x;
      col_eol_q   <= x_last;
      col_eof_q   <= x_last && (y == Y_LAST);
    end else if (bus.col_ready) begin
      col_valid_q <= 1'b0;
    end
  end

endmodule
